rf_wb_arbiter: RTL

//  Shares the register file's single write port between two writeback sources.
//  s0 is the ALU result path and s1 is the load-return path.

---
 rtl/rf_wb_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-source register-file writeback arbiter (s0 ALU priority, s1 load starvation guard), registered write port; ports clk/rst, s0_*/s1_* valid-ready requests, rf_we/rf_waddr/rf_wdata, starve_o; optional RF_WB_BYPASS_EN adds raddr1/2, rf_rdata1/2, byp_rdata1/2
module rf_wb_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          starve_o
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic [DW-1:0] byp_rdata1,
  output logic [DW-1:0] byp_rdata2
`endif
);
  localparam int CW = MAX_WAIT < 1 ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          force_1, grant_0, grant_1, accept;
  logic [AW-1:0] win_addr, rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] win_data, rf_wdata_q, rf_wdata_d;
  logic          rf_we_q, rf_we_d;
  always_comb begin
    force_1    = wait_cnt_q >= MAXC;
    grant_1    = !rst && s1_valid && (!s0_valid || force_1);
    grant_0    = !rst && s0_valid && !grant_1;
    starve_o   = !rst && s0_valid && s1_valid && force_1;
    accept     = grant_0 || grant_1;
    win_addr   = grant_1 ? s1_addr : s0_addr;
    win_data   = grant_1 ? s1_data : s0_data;
    wait_cnt_d = (rst || !s1_valid || grant_1) ? '0 :
                 (wait_cnt_q == MAXC) ? wait_cnt_q : wait_cnt_q + 1'b1;
    rf_we_d    = accept && win_addr != '0;
    rf_waddr_d = rst ? '0 : accept ? win_addr : rf_waddr_q;
    rf_wdata_d = rst ? '0 : accept ? win_data : rf_wdata_q;
  end
  always_ff @(posedge clk) begin
    wait_cnt_q <= wait_cnt_d;
    rf_we_q    <= rf_we_d;
    rf_waddr_q <= rf_waddr_d;
    rf_wdata_q <= rf_wdata_d;
  end
  assign s0_ready = grant_0;
  assign s1_ready = grant_1;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
`ifdef RF_WB_BYPASS_EN
  always_comb begin
    byp_rdata1 = (rf_we_q && rf_waddr_q == raddr1 && raddr1 != '0) ? rf_wdata_q : rf_rdata1;
    byp_rdata2 = (rf_we_q && rf_waddr_q == raddr2 && raddr2 != '0) ? rf_wdata_q : rf_rdata2;
  end
`endif
endmodule
